// File: rtl/vga_timing_generator.sv
// VGA timing generator: pixel-tick driven x/y counters with frame-boundary
// shadowing of run-time mode inputs, registered sync/video/strobe outputs.
module vga_timing_generator #(
  parameter int unsigned XW = 10,
  parameter int unsigned YW = 10
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_pixel_clk,
  input  logic          i_enable,
  input  logic [XW-1:0] i_h_active,
  input  logic [XW-1:0] i_h_front,
  input  logic [XW-1:0] i_h_sync,
  input  logic [XW-1:0] i_h_back,
  input  logic [YW-1:0] i_v_active,
  input  logic [YW-1:0] i_v_front,
  input  logic [YW-1:0] i_v_sync,
  input  logic [YW-1:0] i_v_back,
  input  logic          i_hsync_pol,
  input  logic          i_vsync_pol,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic [XW-1:0] o_xposition,
  output logic [YW-1:0] o_yposition,
  output logic          o_video_on,
  output logic          o_line_end,
  output logic          o_frame_end,
  output logic          o_config_error
);

  localparam int unsigned HCW = XW + 2;
  localparam int unsigned VCW = YW + 2;
  localparam logic [HCW-1:0] H_LIMIT = HCW'(1) << XW;
  localparam logic [VCW-1:0] V_LIMIT = VCW'(1) << YW;

  logic r_pix_s1, r_pix_s2, r_pix_prev;
  logic w_tick;

  logic [XW-1:0] r_sh_ha, r_sh_hf, r_sh_hs, r_sh_hb;
  logic [YW-1:0] r_sh_va, r_sh_vf, r_sh_vs, r_sh_vb;
  logic          r_sh_hpol, r_sh_vpol;

  logic [XW-1:0] w_sh_ha_n, w_sh_hf_n, w_sh_hs_n, w_sh_hb_n;
  logic [YW-1:0] w_sh_va_n, w_sh_vf_n, w_sh_vs_n, w_sh_vb_n;
  logic          w_sh_hpol_n, w_sh_vpol_n;

  logic [HCW-1:0] w_h_tot, w_h_tot_n, w_hs_lo_n, w_hs_hi_n, w_x_ext_n;
  logic [VCW-1:0] w_v_tot, w_v_tot_n, w_vs_lo_n, w_vs_hi_n, w_y_ext_n;
  logic           w_bad, w_bad_n, w_run, w_load;
  logic           w_x_last, w_y_last;

  logic [XW-1:0] r_x, w_x_n;
  logic [YW-1:0] r_y, w_y_n;
  logic          r_hsync, r_vsync, r_video_on, r_line_end, r_frame_end, r_cfg_err;

  // PixelClock synchroniser and falling-edge detect
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pix_s1   <= 1'b0;
      r_pix_s2   <= 1'b0;
      r_pix_prev <= 1'b0;
    end else begin
      r_pix_s1   <= i_pixel_clk;
      r_pix_s2   <= r_pix_s1;
      r_pix_prev <= r_pix_s2;
    end
  end

  assign w_tick = r_pix_prev & ~r_pix_s2;

  // Totals and legality of the active (shadow) mode
  always_comb begin
    w_h_tot = HCW'(r_sh_ha) + HCW'(r_sh_hf) + HCW'(r_sh_hs) + HCW'(r_sh_hb);
    w_v_tot = VCW'(r_sh_va) + VCW'(r_sh_vf) + VCW'(r_sh_vs) + VCW'(r_sh_vb);
    w_bad   = (w_h_tot > H_LIMIT) || (w_v_tot > V_LIMIT) ||
              (r_sh_hs == '0) || (r_sh_vs == '0) ||
              (r_sh_ha == '0) || (r_sh_va == '0);
  end

  assign w_run    = i_enable & ~w_bad;
  assign w_x_last = (HCW'(r_x) == (w_h_tot - HCW'(1)));
  assign w_y_last = (VCW'(r_y) == (w_v_tot - VCW'(1)));
  // Reload while idle/illegal, otherwise only on the tick that wraps the frame
  assign w_load   = ~w_run | (w_tick & w_x_last & w_y_last);

  always_comb begin
    w_sh_ha_n   = r_sh_ha;
    w_sh_hf_n   = r_sh_hf;
    w_sh_hs_n   = r_sh_hs;
    w_sh_hb_n   = r_sh_hb;
    w_sh_va_n   = r_sh_va;
    w_sh_vf_n   = r_sh_vf;
    w_sh_vs_n   = r_sh_vs;
    w_sh_vb_n   = r_sh_vb;
    w_sh_hpol_n = r_sh_hpol;
    w_sh_vpol_n = r_sh_vpol;
    if (w_load) begin
      w_sh_ha_n   = i_h_active;
      w_sh_hf_n   = i_h_front;
      w_sh_hs_n   = i_h_sync;
      w_sh_hb_n   = i_h_back;
      w_sh_va_n   = i_v_active;
      w_sh_vf_n   = i_v_front;
      w_sh_vs_n   = i_v_sync;
      w_sh_vb_n   = i_v_back;
      w_sh_hpol_n = i_hsync_pol;
      w_sh_vpol_n = i_vsync_pol;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sh_ha   <= '0;
      r_sh_hf   <= '0;
      r_sh_hs   <= '0;
      r_sh_hb   <= '0;
      r_sh_va   <= '0;
      r_sh_vf   <= '0;
      r_sh_vs   <= '0;
      r_sh_vb   <= '0;
      r_sh_hpol <= 1'b0;
      r_sh_vpol <= 1'b0;
    end else begin
      r_sh_ha   <= w_sh_ha_n;
      r_sh_hf   <= w_sh_hf_n;
      r_sh_hs   <= w_sh_hs_n;
      r_sh_hb   <= w_sh_hb_n;
      r_sh_va   <= w_sh_va_n;
      r_sh_vf   <= w_sh_vf_n;
      r_sh_vs   <= w_sh_vs_n;
      r_sh_vb   <= w_sh_vb_n;
      r_sh_hpol <= w_sh_hpol_n;
      r_sh_vpol <= w_sh_vpol_n;
    end
  end

  // Position counters
  always_comb begin
    w_x_n = r_x;
    w_y_n = r_y;
    if (!w_run) begin
      w_x_n = '0;
      w_y_n = '0;
    end else if (w_tick) begin
      if (w_x_last) begin
        w_x_n = '0;
        w_y_n = w_y_last ? '0 : r_y + YW'(1);
      end else begin
        w_x_n = r_x + XW'(1);
      end
    end
  end

  // Output decode uses the mode that will be in force alongside the new position
  always_comb begin
    w_h_tot_n = HCW'(w_sh_ha_n) + HCW'(w_sh_hf_n) + HCW'(w_sh_hs_n) + HCW'(w_sh_hb_n);
    w_v_tot_n = VCW'(w_sh_va_n) + VCW'(w_sh_vf_n) + VCW'(w_sh_vs_n) + VCW'(w_sh_vb_n);
    w_bad_n   = (w_h_tot_n > H_LIMIT) || (w_v_tot_n > V_LIMIT) ||
                (w_sh_hs_n == '0) || (w_sh_vs_n == '0) ||
                (w_sh_ha_n == '0) || (w_sh_va_n == '0);
    w_hs_lo_n = HCW'(w_sh_ha_n) + HCW'(w_sh_hf_n);
    w_hs_hi_n = w_hs_lo_n + HCW'(w_sh_hs_n);
    w_vs_lo_n = VCW'(w_sh_va_n) + VCW'(w_sh_vf_n);
    w_vs_hi_n = w_vs_lo_n + VCW'(w_sh_vs_n);
    w_x_ext_n = HCW'(w_x_n);
    w_y_ext_n = VCW'(w_y_n);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_x         <= '0;
      r_y         <= '0;
      r_hsync     <= 1'b1;
      r_vsync     <= 1'b1;
      r_video_on  <= 1'b0;
      r_line_end  <= 1'b0;
      r_frame_end <= 1'b0;
      r_cfg_err   <= 1'b0;
    end else begin
      r_x       <= w_x_n;
      r_y       <= w_y_n;
      r_cfg_err <= w_bad_n;
      if (!w_run) begin
        r_hsync     <= ~w_sh_hpol_n;
        r_vsync     <= ~w_sh_vpol_n;
        r_video_on  <= 1'b0;
        r_line_end  <= 1'b0;
        r_frame_end <= 1'b0;
      end else begin
        r_hsync     <= ((w_x_ext_n >= w_hs_lo_n) && (w_x_ext_n < w_hs_hi_n)) ?
                       w_sh_hpol_n : ~w_sh_hpol_n;
        r_vsync     <= ((w_y_ext_n >= w_vs_lo_n) && (w_y_ext_n < w_vs_hi_n)) ?
                       w_sh_vpol_n : ~w_sh_vpol_n;
        r_video_on  <= (w_x_n < w_sh_ha_n) && (w_y_n < w_sh_va_n);
        r_line_end  <= w_tick & w_x_last;
        r_frame_end <= w_tick & w_x_last & w_y_last;
      end
    end
  end

  assign o_xposition    = r_x;
  assign o_yposition    = r_y;
  assign o_hsync        = r_hsync;
  assign o_vsync        = r_vsync;
  assign o_video_on     = r_video_on;
  assign o_line_end     = r_line_end;
  assign o_frame_end    = r_frame_end;
  assign o_config_error = r_cfg_err;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench for vga_timing_generator: small mode M, mode change, polarity,
// illegal configs, async reset and one 640x480 line.
module tb_vga_timing_generator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix = 1'b0;
  logic       en = 1'b0;
  logic [9:0] ha, hf, hs, hb, va, vf, vs, vb;
  logic       hpol = 1'b0, vpol = 1'b0;
  logic       o_hsync, o_vsync, o_video_on, o_line_end, o_frame_end, o_config_error;
  logic [9:0] o_x, o_y;

  int n_cmp = 0;
  int n_err = 0;
  int le_cnt = 0, fe_cnt = 0, fe_alone = 0;

  vga_timing_generator #(.XW(10), .YW(10)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pixel_clk(pix), .i_enable(en),
    .i_h_active(ha), .i_h_front(hf), .i_h_sync(hs), .i_h_back(hb),
    .i_v_active(va), .i_v_front(vf), .i_v_sync(vs), .i_v_back(vb),
    .i_hsync_pol(hpol), .i_vsync_pol(vpol),
    .o_hsync(o_hsync), .o_vsync(o_vsync), .o_xposition(o_x), .o_yposition(o_y),
    .o_video_on(o_video_on), .o_line_end(o_line_end), .o_frame_end(o_frame_end),
    .o_config_error(o_config_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_line_end) le_cnt++;
    if (o_frame_end) fe_cnt++;
    if (o_frame_end && !o_line_end) fe_alone++;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_mode(input int a, input int f, input int s, input int b,
                          input int a2, input int f2, input int s2, input int b2);
    ha = 10'(a); hf = 10'(f); hs = 10'(s); hb = 10'(b);
    va = 10'(a2); vf = 10'(f2); vs = 10'(s2); vb = 10'(b2);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One PixelClock period; returns at a negedge after outputs have settled
  task automatic do_tick();
    @(negedge clk) pix = 1'b1;
    wait_clk(3);
    pix = 1'b0;
    wait_clk(4);
  endtask

  task automatic restart_mode_m();
    en = 1'b0;
    set_mode(4, 1, 2, 1, 3, 1, 1, 1);
    wait_clk(2);
    en = 1'b1;
    wait_clk(2);
  endtask

  int ex, ey, le0, fe0, hs_n;

  initial begin
    set_mode(4, 1, 2, 1, 3, 1, 1, 1);
    wait_clk(3);
    chk("reset_x", 32'(o_x), 0);
    chk("reset_hsync", 32'(o_hsync), 1);
    chk("reset_video", 32'(o_video_on), 0);
    chk("reset_cfg", 32'(o_config_error), 0);
    rst_n = 1'b1;
    wait_clk(3);
    en = 1'b1;
    wait_clk(2);
    chk("en_start_x", 32'(o_x), 0);
    chk("en_start_video", 32'(o_video_on), 1);

    // Mode M, one full frame of 48 ticks
    le0 = le_cnt; fe0 = fe_cnt;
    for (int t = 1; t <= 48; t++) begin
      do_tick();
      ex = t % 8; ey = (t / 8) % 6;
      chk("m_x", 32'(o_x), 32'(ex));
      chk("m_y", 32'(o_y), 32'(ey));
      chk("m_hsync", 32'(o_hsync), (ex == 5 || ex == 6) ? 0 : 1);
      chk("m_vsync", 32'(o_vsync), (ey == 4) ? 0 : 1);
      chk("m_video", 32'(o_video_on), (ex < 4 && ey < 3) ? 1 : 0);
      if (t == 8) chk("m_le_first_line", 32'(le_cnt - le0), 1);
      if (t == 8) chk("m_fe_first_line", 32'(fe_cnt - fe0), 0);
    end
    chk("m_le_frame", 32'(le_cnt - le0), 6);
    chk("m_fe_frame", 32'(fe_cnt - fe0), 1);
    chk("m_fe_alone", 32'(fe_alone), 0);

    // No ticks: position holds
    wait_clk(12);
    chk("hold_x", 32'(o_x), 0);

    // HActive change mid-frame takes effect after FrameEnd
    for (int t = 0; t < 19; t++) do_tick();
    chk("chg_at_x", 32'(o_x), 3);
    chk("chg_at_y", 32'(o_y), 2);
    ha = 10'd6;
    fe0 = fe_cnt;
    for (int t = 0; t < 29; t++) do_tick();
    chk("chg_wrap_x", 32'(o_x), 0);
    chk("chg_wrap_y", 32'(o_y), 0);
    chk("chg_fe", 32'(fe_cnt - fe0), 1);
    for (int t = 0; t < 7; t++) do_tick();
    chk("chg_x7", 32'(o_x), 7);
    chk("chg_hs7", 32'(o_hsync), 0);
    do_tick();
    chk("chg_hs8", 32'(o_hsync), 0);
    do_tick();
    chk("chg_x9", 32'(o_x), 9);
    chk("chg_hs9", 32'(o_hsync), 1);
    do_tick();
    chk("chg_wrap10_x", 32'(o_x), 0);
    chk("chg_wrap10_y", 32'(o_y), 1);

    // Positive sync polarity
    en = 1'b0;
    hpol = 1'b1; vpol = 1'b1;
    set_mode(4, 1, 2, 1, 3, 1, 1, 1);
    wait_clk(2);
    chk("pol_idle_hs", 32'(o_hsync), 0);
    chk("pol_idle_vs", 32'(o_vsync), 0);
    chk("dis_x", 32'(o_x), 0);
    chk("dis_y", 32'(o_y), 0);
    en = 1'b1;
    wait_clk(2);
    for (int t = 1; t <= 48; t++) begin
      do_tick();
      ex = t % 8; ey = (t / 8) % 6;
      chk("pol_hsync", 32'(o_hsync), (ex == 5 || ex == 6) ? 1 : 0);
      chk("pol_vsync", 32'(o_vsync), (ey == 4) ? 1 : 0);
    end
    hpol = 1'b0; vpol = 1'b0;

    // Illegal configurations
    en = 1'b0;
    set_mode(4, 1, 0, 1, 3, 1, 1, 1);
    wait_clk(2);
    chk("cfg_hs0", 32'(o_config_error), 1);
    en = 1'b1;
    for (int t = 0; t < 3; t++) do_tick();
    chk("cfg_hs0_x", 32'(o_x), 0);
    chk("cfg_hs0_y", 32'(o_y), 0);
    chk("cfg_hs0_video", 32'(o_video_on), 0);
    set_mode(1023, 1, 2, 1, 3, 1, 1, 1);
    wait_clk(2);
    chk("cfg_ha1023", 32'(o_config_error), 1);
    do_tick();
    chk("cfg_ha1023_x", 32'(o_x), 0);
    en = 1'b0;
    set_mode(1020, 1, 2, 1, 3, 1, 1, 1);
    wait_clk(2);
    chk("cfg_total1024", 32'(o_config_error), 0);
    set_mode(4, 1, 2, 1, 3, 1, 1, 1);
    wait_clk(2);
    chk("cfg_restored", 32'(o_config_error), 0);
    en = 1'b1;
    wait_clk(2);
    do_tick();
    chk("cfg_resume_x", 32'(o_x), 1);

    // Asynchronous reset mid-frame
    restart_mode_m();
    for (int t = 0; t < 29; t++) do_tick();
    chk("rst_pre_x", 32'(o_x), 5);
    chk("rst_pre_y", 32'(o_y), 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_async_x", 32'(o_x), 0);
    chk("rst_async_y", 32'(o_y), 0);
    chk("rst_async_hsync", 32'(o_hsync), 1);
    chk("rst_async_vsync", 32'(o_vsync), 1);
    chk("rst_async_video", 32'(o_video_on), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clk(3);
    chk("rst_restart_x", 32'(o_x), 0);
    do_tick();
    chk("rst_tick_x", 32'(o_x), 1);
    chk("rst_tick_y", 32'(o_y), 0);

    // 640x480: one full 800-pixel line with a 96-pixel hsync
    en = 1'b0;
    set_mode(640, 16, 96, 48, 480, 10, 2, 33);
    wait_clk(2);
    chk("vga_cfg", 32'(o_config_error), 0);
    en = 1'b1;
    wait_clk(2);
    le0 = le_cnt;
    hs_n = 0;
    for (int t = 1; t <= 800; t++) begin
      do_tick();
      if (!o_hsync) hs_n++;
      if (t == 799) chk("vga_x799", 32'(o_x), 799);
      if (t == 656) chk("vga_hs_start", 32'(o_hsync), 0);
      if (t == 752) chk("vga_hs_end", 32'(o_hsync), 1);
    end
    chk("vga_wrap_x", 32'(o_x), 0);
    chk("vga_wrap_y", 32'(o_y), 1);
    chk("vga_le", 32'(le_cnt - le0), 1);
    chk("vga_hs_width", 32'(hs_n), 96);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
